// File: rtl/cascaded_vedic_divider_16bit.sv
// rtl/cascaded_vedic_divider_16bit.sv - sequential unsigned divider, cascaded 16-bit stages, start/done handshake
// One quotient bit per cycle MSB first; results held from completion until the next accepted start.
module cascaded_vedic_divider_16bit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done
);

  localparam int NSTAGE = WIDTH / 16;
  localparam int SW     = (NSTAGE > 1) ? $clog2(NSTAGE) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q,     state_d;
  logic [WIDTH-1:0] dq_q,        dq_d;
  logic [WIDTH-1:0] dvs_q,       dvs_d;
  logic [WIDTH-1:0] rem_q,       rem_d;
  logic [SW-1:0]    stage_q,     stage_d;
  logic [3:0]       bit_q,       bit_d;
  logic [WIDTH-1:0] quotient_q,  quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             done_q,      done_d;

  logic [WIDTH:0]   trial;
  logic             q_bit;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] dq_next;
  logic             last_iter;

  // dq holds the unconsumed dividend bits on top and the working quotient
  // bits filling in from the bottom, so after WIDTH shifts it is the quotient.
  always_comb begin
    trial     = {rem_q, dq_q[WIDTH-1]};
    q_bit     = (trial >= {1'b0, dvs_q});
    rem_next  = q_bit ? (trial[WIDTH-1:0] - dvs_q) : trial[WIDTH-1:0];
    dq_next   = {dq_q[WIDTH-2:0], q_bit};
    last_iter = (stage_q == '0) && (bit_q == 4'd15);
  end

  always_comb begin
    state_d     = state_q;
    dq_d        = dq_q;
    dvs_d       = dvs_q;
    rem_d       = rem_q;
    stage_d     = stage_q;
    bit_d       = bit_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    done_d      = done_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          dq_d    = dividend;
          dvs_d   = divisor;
          rem_d   = '0;
          stage_d = SW'(NSTAGE - 1);
          bit_d   = 4'd0;
          done_d  = 1'b0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        dq_d  = dq_next;
        rem_d = rem_next;
        bit_d = bit_q + 4'd1;
        // Each 16-bit group resolved moves on to the next less significant group.
        if (bit_q == 4'd15) begin
          stage_d = stage_q - SW'(1);
        end
        if (last_iter) begin
          quotient_d  = dq_next;
          remainder_d = rem_next;
          done_d      = 1'b1;
          state_d     = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      dq_q        <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      stage_q     <= '0;
      bit_q       <= 4'd0;
      quotient_q  <= '0;
      remainder_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      dq_q        <= dq_d;
      dvs_q       <= dvs_d;
      rem_q       <= rem_d;
      stage_q     <= stage_d;
      bit_q       <= bit_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      done_q      <= done_d;
    end
  end

  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign done      = done_q;

endmodule

// File: tb/tb_cascaded_vedic_divider_16bit.sv
// tb/tb_cascaded_vedic_divider_16bit.sv - self-checking bench for cascaded_vedic_divider_16bit
// Edge-counting reference model checked every cycle, plus directed literal expectations.
module tb_cascaded_vedic_divider_16bit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        done;

  int tests = 0;
  int fails = 0;

  cascaded_vedic_divider_16bit #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: results appear 33 edges after acceptance, computed with plain arithmetic.
  logic        m_valid = 1'b0;
  logic        m_busy;
  int          m_cnt;
  logic        m_done;
  logic [31:0] m_a, m_b, m_q, m_r;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy  = 1'b0;
      m_cnt   = 0;
      m_done  = 1'b0;
      m_q     = 32'd0;
      m_r     = 32'd0;
      m_valid = 1'b1;
    end else if (m_busy) begin
      m_cnt = m_cnt - 1;
      if (m_cnt == 0) begin
        m_busy = 1'b0;
        m_done = 1'b1;
        m_q    = (m_b == 32'd0) ? 32'hFFFF_FFFF : m_a / m_b;
        m_r    = (m_b == 32'd0) ? m_a : m_a % m_b;
      end
    end else if (start) begin
      m_a    = dividend;
      m_b    = divisor;
      m_busy = 1'b1;
      m_cnt  = 32;
      m_done = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("cyc_done", {31'd0, done}, {31'd0, m_done});
      check("cyc_quotient", quotient, m_q);
      check("cyc_remainder", remainder, m_r);
    end
  end

  task automatic do_op(input logic [31:0] a, input logic [31:0] b, output int lat, output logic done_after_accept);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    done_after_accept = done;
    lat = 1;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  logic [31:0] tab_a [4] = '{32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'd1234};
  logic [31:0] tab_b [4] = '{32'd1, 32'd7, 32'hFFFF_FFFF, 32'd0};
  logic [31:0] tab_q [4] = '{32'hFFFF_FFFF, 32'd0, 32'd1, 32'hFFFF_FFFF};
  logic [31:0] tab_r [4] = '{32'd0, 32'd5, 32'd0, 32'd1234};

  initial begin
    int          lat;
    logic        dac;
    logic [31:0] a, b;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = 32'd0;
    divisor  = 32'd0;
    repeat (3) @(negedge clk);
    check("reset_quotient", quotient, 32'd0);
    check("reset_remainder", remainder, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;

    do_op(32'd12540000, 32'd98, lat, dac);
    check("op1_latency", lat, 33);
    check("op1_quotient", quotient, 32'd127959);
    check("op1_remainder", remainder, 32'd18);
    repeat (5) @(negedge clk);
    check("op1_hold_quotient", quotient, 32'd127959);
    check("op1_hold_done", {31'd0, done}, 32'd1);

    do_op(32'd8610000, 32'd700, lat, dac);
    check("op2_done_drop", {31'd0, dac}, 32'd0);
    check("op2_latency", lat, 33);
    check("op2_quotient", quotient, 32'd12300);
    check("op2_remainder", remainder, 32'd0);

    for (int i = 0; i < 4; i++) begin
      do_op(tab_a[i], tab_b[i], lat, dac);
      check("edge_latency", lat, 33);
      check("edge_quotient", quotient, tab_q[i]);
      check("edge_remainder", remainder, tab_r[i]);
    end

    // Start pulse and operand changes during CALC must be ignored.
    @(negedge clk);
    dividend = 32'd1000000;
    divisor  = 32'd37;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    dividend = 32'd5;
    divisor  = 32'd3;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    dividend = 32'd99;
    lat = 12;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("robust_latency", lat, 33);
    check("robust_quotient", quotient, 32'd27027);
    check("robust_remainder", remainder, 32'd1);

    // Reset mid-CALC aborts and clears outputs.
    @(negedge clk);
    dividend = 32'd777;
    divisor  = 32'd5;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_quotient", quotient, 32'd0);
    check("abort_remainder", remainder, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("abort_no_result", {31'd0, done}, 32'd0);

    for (int i = 0; i < 1000; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = $urandom;
        1: b = $urandom_range(1, 255);
        2: b = $urandom >> $urandom_range(0, 31);
        default: b = a >> $urandom_range(0, 8);
      endcase
      if (i % 50 == 0) b = 32'd0;
      do_op(a, b, lat, dac);
      check("rand_latency", lat, 33);
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cascaded_vedic_divider_16bit.md
Name: cascaded_vedic_divider_16bit

Overview:
Sequential unsigned integer divider producing quotient and remainder of a WIDTH-bit dividend by a WIDTH-bit divisor. The quotient is computed in cascaded 16-bit stages (Dhvajanka-style digit grouping), each stage resolving 16 quotient bits one bit per cycle with shift-subtract. The block sits as a multi-cycle arithmetic unit behind a start/done handshake, with results held until the next operation.

Parameters:
WIDTH, 32, operand/result width in bits; must be a multiple of 16 and at least 16; number of cascaded 16-bit stages = WIDTH/16.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
start  input  1  request to begin a division; sampled on the rising edge only in IDLE or DONE.
dividend  input  WIDTH  unsigned dividend; captured on the accepting edge.
divisor  input  WIDTH  unsigned divisor; captured on the accepting edge.
quotient  output  WIDTH  unsigned quotient (registered).
remainder  output  WIDTH  unsigned remainder (registered).
done  output  1  result-valid level; high from completion until the next accepted start.

Behaviour:
- Reset (rst_n=0 at a rising edge): state=IDLE; quotient=0, remainder=0, done=0; internal partial remainder, working quotient, stage counter and bit counter all cleared. Reset overrides start and aborts any in-progress division with no result written.
- States: IDLE, CALC, DONE.
- IDLE/DONE with start=1: capture dividend and divisor into internal registers, clear partial remainder, clear done, set bit counter=0, go to CALC. This is the accepting edge.
- Start in CALC is ignored; captured operands are not disturbed by input changes after acceptance.
- CALC: one quotient bit per cycle, MSB first.
  - Partial remainder is WIDTH+1 bits wide: shift in next dividend bit; if the result >= divisor, subtract and set the quotient bit to 1, else 0.
  - Every 16 iterations completes one cascaded 16-bit stage; the stage index advances from the most significant 16-bit group to the least.
- After exactly WIDTH iterations: on the same edge, write quotient and remainder outputs, set done=1, go to DONE.
- Latency: done is high after WIDTH+1 rising edges counted from and including the accepting edge (33 edges for WIDTH=32). Latency is fixed and independent of operand values.
- quotient/remainder hold previous values during CALC and change only on the completion edge.
- DONE: outputs and done hold indefinitely. A start in DONE is accepted exactly as in IDLE, and done falls on that accepting edge.
- Divide by zero (divisor=0): normal fixed latency; quotient = all ones, remainder = dividend, done asserted normally.
- Dividend < divisor: quotient=0, remainder=dividend.
- Divisor=1: quotient=dividend, remainder=0.
- Results always satisfy dividend = quotient*divisor + remainder with remainder < divisor, for divisor != 0.

Test Plan:
- Reset, then start with 12540000 / 98 -> done after 33 edges; quotient=127959, remainder=18; outputs stable while done is high.
- Back-to-back op: from DONE, start with 8610000 / 700 -> done drops on the accepting edge, returns after 33 edges; quotient=12300, remainder=0.
- Edge operands: 0xFFFFFFFF / 1 -> quotient=0xFFFFFFFF, rem=0; 5 / 7 -> q=0, r=5; 0xFFFFFFFF / 0xFFFFFFFF -> q=1, r=0.
- Divide by zero: 1234 / 0 -> q=0xFFFFFFFF, r=1234, done after 33 edges.
- Robustness: pulse start again and change dividend/divisor mid-CALC -> ignored, original result delivered. Assert rst_n=0 mid-CALC -> next edge gives q=0, r=0, done=0, IDLE.
- Randomized 1000 pairs vs reference model (q=a/b, r=a%b; div-by-zero rule) with fixed 33-edge latency check.
